// File: rtl/generador_pasos_step.sv
// STEP pulse sequencer for an A4988 driver: latches DIR/MS when a move starts,
// then emits numPasos STEP pulses periodo cycles apart, honouring setup and min high/low times.
module generador_pasos_step #(
  parameter int unsigned STEP_HIGH_CYC = 50,
  parameter int unsigned SETUP_CYC     = 25,
  parameter int unsigned PERIOD_W      = 24,
  parameter int unsigned COUNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic [COUNT_W-1:0]  numPasos,
  input  logic [PERIOD_W-1:0] periodo,
  input  logic                dirIn,
  input  logic [2:0]          msIn,
  output logic                STEP,
  output logic                DIR,
  output logic [2:0]          MS,
  output logic                busy,
  output logic                done,
  output logic [COUNT_W-1:0]  pasosRestantes,
  output logic [2:0]          o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [PERIOD_W-1:0] P_MIN      = PERIOD_W'(2 * STEP_HIGH_CYC);
  localparam logic [PERIOD_W-1:0] HIGH_LAST  = PERIOD_W'(STEP_HIGH_CYC - 1);
  localparam logic [PERIOD_W-1:0] SETUP_LAST = PERIOD_W'(SETUP_CYC - 1);
  localparam logic [PERIOD_W-1:0] LOW_OFFS   = PERIOD_W'(STEP_HIGH_CYC + 1);

  state_t              r_state;
  logic [PERIOD_W-1:0] r_cnt;
  logic [PERIOD_W-1:0] r_low_last;
  logic                r_abort;
  logic                r_step;
  logic                r_dir;
  logic [2:0]          r_ms;
  logic                r_busy;
  logic                r_done;
  logic [COUNT_W-1:0]  r_rest;

  logic [PERIOD_W-1:0] w_per_cl;
  logic [PERIOD_W-1:0] w_low_last_in;
  logic                w_abort;
  logic                w_rest_zero;
  logic [COUNT_W-1:0]  w_rest_dec;
  logic                w_low_exit;

  // Short periods are clamped so LOW can never be shorter than the minimum low time.
  assign w_per_cl      = (periodo < P_MIN) ? P_MIN : periodo;
  assign w_low_last_in = w_per_cl - LOW_OFFS;
  assign w_abort       = r_abort | stop;
  assign w_rest_zero   = (r_rest == '0);
  assign w_rest_dec    = w_rest_zero ? r_rest : (r_rest - COUNT_W'(1));
  // An abort shortens LOW to the minimum low time, or ends it at once if that has already elapsed.
  assign w_low_exit    = (r_cnt == r_low_last) || (w_abort && (r_cnt >= HIGH_LAST));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_low_last <= '0;
      r_abort    <= 1'b0;
      r_step     <= 1'b0;
      r_dir      <= 1'b0;
      r_ms       <= 3'b000;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rest     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !stop) begin
            r_dir      <= dirIn;
            r_ms       <= msIn;
            r_rest     <= numPasos;
            r_low_last <= w_low_last_in;
            r_cnt      <= '0;
            if (numPasos != '0) begin
              r_state <= S_SETUP;
              r_busy  <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_SETUP: begin
          if (stop) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (r_cnt == SETUP_LAST) begin
            r_state <= S_HIGH;
            r_step  <= 1'b1;
            r_cnt   <= '0;
            r_rest  <= w_rest_dec;
          end else begin
            r_cnt <= r_cnt + PERIOD_W'(1);
          end
        end
        S_HIGH: begin
          r_abort <= w_abort;
          if (r_cnt == HIGH_LAST) begin
            r_state <= S_LOW;
            r_step  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + PERIOD_W'(1);
          end
        end
        S_LOW: begin
          r_abort <= w_abort;
          if (w_low_exit) begin
            if (w_rest_zero || w_abort) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_HIGH;
              r_step  <= 1'b1;
              r_cnt   <= '0;
              r_rest  <= w_rest_dec;
            end
          end else begin
            r_cnt <= r_cnt + PERIOD_W'(1);
          end
        end
        S_DONE: begin
          r_abort <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_step  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign STEP           = r_step;
  assign DIR            = r_dir;
  assign MS             = r_ms;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pasosRestantes = r_rest;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_generador_pasos_step.sv
// Randomized bench for generador_pasos_step: a timing model of each move fills
// expected queues, and a negedge monitor pops and compares STEP rises and done pulses.
module tb_generador_pasos_step;
  localparam int HI = 50;
  localparam int SU = 25;
  localparam int PW = 24;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stop;
  logic [CW-1:0] numPasos;
  logic [PW-1:0] periodo;
  logic          dirIn;
  logic [2:0]    msIn;
  logic          STEP;
  logic          DIR;
  logic [2:0]    MS;
  logic          busy;
  logic          done;
  logic [CW-1:0] pasosRestantes;
  logic [2:0]    dbg_state;

  generador_pasos_step dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .numPasos(numPasos), .periodo(periodo), .dirIn(dirIn), .msIn(msIn),
    .STEP(STEP), .DIR(DIR), .MS(MS), .busy(busy), .done(done),
    .pasosRestantes(pasosRestantes), .o_dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  // expected queues: rise cycle; done record {cycle, busy cycles, residue, dir, ms}
  logic [31:0] exp_rise_q[$];
  logic [83:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // monitor
  initial begin : monitor
    logic        prev_step;
    int          hw;
    int          bcnt;
    logic [83:0] e;
    logic [31:0] er;
    prev_step = 1'b0;
    hw = 0;
    bcnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_step = 1'b0;
        hw = 0;
        bcnt = 0;
      end else begin
        if (STEP && !prev_step) begin
          if (exp_rise_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_rise: STEP rose at cycle %0d with none expected", cyc);
          end else begin
            er = exp_rise_q.pop_front();
            check("rise_cycle", 64'(cyc), 64'(er));
          end
          hw = 0;
        end
        if (STEP) hw++;
        if (!STEP && prev_step) check("step_high_width", 64'(hw), 64'(HI));
        if (busy) bcnt++;
        if (done) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_done: done at cycle %0d with none expected", cyc);
          end else begin
            e = exp_q.pop_front();
            check("done_cycle", 64'(cyc), 64'(e[83:52]));
            check("busy_cycles", 64'(bcnt), 64'(e[51:20]));
            check("rest_at_done", 64'(pasosRestantes), 64'(e[19:4]));
            check("dir_latched", 64'(DIR), 64'(e[3]));
            check("ms_latched", 64'(MS), 64'(e[2:0]));
            check("done_step_low", 64'(STEP), 64'(0));
          end
          bcnt = 0;
        end
        prev_step = STEP;
      end
    end
  end

  // Reference model + driver. Called just after a rising edge; start is sampled at the next edge.
  // s/spur/tog: 0 = none, -1 = random, otherwise the cycle (relative to acceptance) at which to act.
  task automatic run_move(input int n, input int per, input logic d, input logic [2:0] m,
                          input int s_in, input int spur_in, input int tog_in);
    int p, dn, s, spur, tog, k, o, j, nr, rest, t0;
    p    = (per < 2 * HI) ? 2 * HI : per;
    dn   = (n == 0) ? 1 : SU + 1 + n * p;
    s    = s_in;
    if (s < 0) s = (n == 0) ? 0 : $urandom_range(1, dn - 1);
    if (n == 0) s = 0;
    nr   = n;
    rest = 0;
    if (s > 0) begin
      if (s <= SU) begin
        nr   = 0;
        rest = n;
        dn   = s + 1;
      end else begin
        k    = (s - SU - 1) / p;
        o    = (s - SU - 1) - k * p;
        j    = (o - HI > HI - 1) ? o - HI : HI - 1;
        nr   = k + 1;
        rest = n - k - 1;
        dn   = SU + 1 + k * p + HI + 1 + j;
      end
    end
    spur = spur_in;
    if (spur < 0) spur = (dn >= 3) ? $urandom_range(2, dn - 1) : 0;
    tog = tog_in;
    if (tog < 0) tog = $urandom_range(1, dn);

    t0 = cyc;
    for (int i = 0; i < nr; i++) exp_rise_q.push_back(32'(t0 + SU + 1 + i * p));
    exp_q.push_back({32'(t0 + dn), 32'((n == 0) ? 0 : dn - 1), 16'(rest), d, m});

    numPasos = CW'(n);
    periodo  = PW'(per);
    dirIn    = d;
    msIn     = m;
    stop     = 1'b0;
    start    = 1'b1;
    for (int rel = 1; rel <= dn + 2; rel++) begin
      @(posedge clk); #1;
      start = (rel == spur);
      if (start) numPasos = CW'($urandom_range(1, 8));
      stop = (s > 0) && (rel == s);
      if (rel == tog) begin
        dirIn = ~d;
        msIn  = ~m;
      end
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin : driver
    int n, per, s, spur;
    int t0;
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    numPasos = '0;
    periodo = '0;
    dirIn = 1'b0;
    msIn = 3'b000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_step", 64'(STEP), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_dir_ms", 64'({DIR, MS}), 64'(0));
    check("reset_rest", 64'(pasosRestantes), 64'(0));
    @(posedge clk); #1;

    run_move(3, 200, 1'b1, 3'b110, 0, 0, 0);     // basic three-step move
    run_move(2, 40, 1'b0, 3'b011, 0, 0, 0);      // period clamped to minimum
    run_move(0, 150, 1'b1, 3'b001, 0, 0, 0);     // zero-step move
    run_move(10, 200, 1'b0, 3'b100, 30, 0, 0);   // stop during HIGH
    run_move(4, 300, 1'b1, 3'b111, 10, 0, 0);    // stop during SETUP
    run_move(4, 300, 1'b1, 3'b101, 196, 0, 0);   // stop late in LOW
    run_move(3, 120, 1'b1, 3'b010, 0, 60, 80);   // start while busy, dirIn toggled

    // start and stop together while idle: nothing happens
    start = 1'b1;
    stop = 1'b1;
    numPasos = CW'(5);
    @(posedge clk); #1;
    start = 1'b0;
    stop = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("idle_start_stop_busy", 64'(busy), 64'(0));
    check("idle_start_stop_step", 64'(STEP), 64'(0));
    @(posedge clk); #1;

    for (int i = 0; i < 20; i++) begin
      n    = $urandom_range(0, 4);
      per  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 99) : $urandom_range(100, 250);
      s    = ($urandom_range(0, 9) < 4) ? -1 : 0;
      spur = ($urandom_range(0, 1) == 1) ? -1 : 0;
      run_move(n, per, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), s, spur, -1);
    end

    // reset in the middle of a move
    t0 = cyc;
    exp_rise_q.push_back(32'(t0 + SU + 1));
    numPasos = CW'(10);
    periodo = PW'(200);
    dirIn = 1'b1;
    msIn = 3'b101;
    start = 1'b1;
    for (int rel = 1; rel <= 40; rel++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (rel == 40) rst = 1'b1;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midreset_step", 64'(STEP), 64'(0));
    check("midreset_busy", 64'(busy), 64'(0));
    check("midreset_dir", 64'(DIR), 64'(0));
    check("midreset_ms", 64'(MS), 64'(0));
    check("midreset_rest", 64'(pasosRestantes), 64'(0));
    check("midreset_done", 64'(done), 64'(0));
    repeat (300) @(posedge clk);
    @(negedge clk);

    check("rise_queue_drained", 64'(exp_rise_q.size()), 64'(0));
    check("done_queue_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
